// File: rtl/load_data_formatter.sv
// Load-path formatter: selects a byte or halfword lane, sign- or zero-extends it, and
// passes words and two-beat doublewords through a one-deep valid/ready output register.
module load_data_formatter #(
    parameter  int DATA_W = 32,
    localparam int AL     = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AL-1:0]     in_addr_lo,
    input  logic [1:0]        in_type,
    input  logic              in_unsigned,
    input  logic              in_bypass,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_misalign,
    output logic [15:0]       mis_count,
    input  logic              mis_clear
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DW2  = 1'b1
    } state_t;

    localparam logic [1:0] T_BYTE = 2'b00;
    localparam logic [1:0] T_HALF = 2'b01;
    localparam logic [1:0] T_WORD = 2'b10;
    localparam logic [1:0] T_DW   = 2'b11;

    state_t              state_q, state_d, state_nxt;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic                out_mis_q, out_mis_d;
    logic [15:0]         mis_count_q, mis_count_d;
    logic                accept;
    logic [DATA_W-1:0]   byte_shift;
    logic [DATA_W-1:0]   half_shift;

    function automatic logic [DATA_W-1:0] ext8(input logic [7:0] b, input logic uns);
        return {{(DATA_W-8){b[7] & ~uns}}, b};
    endfunction

    function automatic logic [DATA_W-1:0] ext16(input logic [15:0] h, input logic uns);
        return {{(DATA_W-16){h[15] & ~uns}}, h};
    endfunction

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Lane selection by shifting the addressed lane down to bit 0.
    assign byte_shift = in_data >> {in_addr_lo, 3'b000};
    assign half_shift = in_data >> {in_addr_lo[AL-1:1], 4'b0000};

    always_comb begin
        out_data_d = in_data;
        out_last_d = 1'b1;
        out_mis_d  = 1'b0;
        state_nxt  = S_IDLE;
        if (state_q == S_IDLE && !in_bypass) begin
            unique case (in_type)
                T_BYTE: out_data_d = ext8(byte_shift[7:0], in_unsigned);
                T_HALF: begin
                    if (in_addr_lo[0]) out_mis_d = 1'b1;
                    else               out_data_d = ext16(half_shift[15:0], in_unsigned);
                end
                T_WORD: out_mis_d = (in_addr_lo != '0);
                T_DW: begin
                    if (in_addr_lo != '0) begin
                        out_mis_d = 1'b1;
                    end else begin
                        out_last_d = 1'b0;
                        state_nxt  = S_DW2;
                    end
                end
                default: out_data_d = in_data;
            endcase
        end
        if (out_mis_d) begin
            out_data_d = '0;
            out_last_d = 1'b1;
        end
    end

    always_comb begin
        state_d = accept ? state_nxt : state_q;
        if (mis_clear)
            mis_count_d = '0;
        else if (accept && out_mis_d && mis_count_q != 16'hFFFF)
            mis_count_d = mis_count_q + 16'd1;
        else
            mis_count_d = mis_count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_mis_q   <= 1'b0;
            mis_count_q <= '0;
        end else begin
            state_q     <= state_d;
            mis_count_q <= mis_count_d;
            if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= out_data_d;
                out_last_q  <= out_last_d;
                out_mis_q   <= out_mis_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_last     = out_last_q;
    assign out_misalign = out_mis_q;
    assign mis_count    = mis_count_q;

endmodule

// File: tb/tb_load_data_formatter.sv
// Bench for load_data_formatter: directed cases plus randomized traffic against a reference model.
module tb_load_data_formatter;

    localparam int DATA_W = 32;
    localparam int AL     = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [AL-1:0]     in_addr_lo;
    logic [1:0]        in_type;
    logic              in_unsigned;
    logic              in_bypass;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              out_misalign;
    logic [15:0]       mis_count;
    logic              mis_clear;

    load_data_formatter #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_addr_lo(in_addr_lo), .in_type(in_type), .in_unsigned(in_unsigned),
        .in_bypass(in_bypass),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_misalign(out_misalign),
        .mis_count(mis_count), .mis_clear(mis_clear)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one held output beat, pending-second-beat flag, counter.
    bit          m_valid;
    logic [31:0] m_data;
    bit          m_last;
    bit          m_mis;
    int          m_cnt;
    bit          m_dw_pending;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic ref_fmt(input logic [31:0] d, input int addr, input int typ,
                           input bit uns, input bit byp, input bit pend,
                           output logic [31:0] res, output bit last, output bit mis,
                           output bit pend_next);
        longint unsigned v;
        res = d; last = 1; mis = 0; pend_next = 0;
        if (pend || byp) return;
        case (typ)
            0: begin
                v = (longint'(d) / (longint'(1) << (8 * addr))) % 256;
                if (!uns && v >= 128) v = v + 64'h1_0000_0000 - 256;
                res = v[31:0];
            end
            1: begin
                if (addr % 2 != 0) mis = 1;
                else begin
                    v = (longint'(d) / (longint'(1) << (8 * addr))) % 65536;
                    if (!uns && v >= 32768) v = v + 64'h1_0000_0000 - 65536;
                    res = v[31:0];
                end
            end
            2: mis = (addr != 0);
            default: begin
                if (addr != 0) mis = 1;
                else begin
                    last = 0;
                    pend_next = 1;
                end
            end
        endcase
        if (mis) begin
            res = 0;
            last = 1;
        end
    endtask

    task automatic check_out(input string tag);
        chk({tag, ".vld"}, {31'b0, out_valid}, {31'b0, m_valid});
        if (m_valid) begin
            chk({tag, ".data"}, out_data, m_data);
            chk({tag, ".last"}, {31'b0, out_last}, {31'b0, m_last});
            chk({tag, ".mis"}, {31'b0, out_misalign}, {31'b0, m_mis});
        end
        chk({tag, ".cnt"}, {16'b0, mis_count}, m_cnt[31:0]);
    endtask

    // One cycle: drive at the negedge, update the model across the posedge, check at the next negedge.
    task automatic step(input bit v, input logic [31:0] d, input int addr, input int typ,
                        input bit uns, input bit byp, input bit rdy, input bit clr,
                        input string tag);
        bit exp_rdy, acc, last, mis, pend_n;
        logic [31:0] res;
        in_valid = v; in_data = d; in_addr_lo = addr[AL-1:0]; in_type = typ[1:0];
        in_unsigned = uns; in_bypass = byp; out_ready = rdy; mis_clear = clr;
        #1;
        exp_rdy = !m_valid || rdy;
        chk({tag, ".in_rdy"}, {31'b0, in_ready}, {31'b0, exp_rdy});
        acc = v && exp_rdy;
        ref_fmt(d, addr, typ, uns, byp, m_dw_pending, res, last, mis, pend_n);
        @(posedge clk);
        if (clr) m_cnt = 0;
        else if (acc && mis && m_cnt < 65535) m_cnt++;
        if (acc) begin
            m_valid = 1; m_data = res; m_last = last; m_mis = mis; m_dw_pending = pend_n;
        end else if (rdy) begin
            m_valid = 0;
        end
        @(negedge clk);
        check_out(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 0; in_valid = 0; out_ready = 0; mis_clear = 0;
        in_data = 0; in_addr_lo = 0; in_type = 0; in_unsigned = 0; in_bypass = 0;
        @(posedge clk);
        @(negedge clk);
        m_valid = 0; m_data = 0; m_last = 0; m_mis = 0; m_cnt = 0; m_dw_pending = 0;
        chk({tag, ".vld"}, {31'b0, out_valid}, 32'd0);
        chk({tag, ".data"}, out_data, 32'd0);
        chk({tag, ".last"}, {31'b0, out_last}, 32'd0);
        chk({tag, ".mis"}, {31'b0, out_misalign}, 32'd0);
        chk({tag, ".cnt"}, {16'b0, mis_count}, 32'd0);
        rst_n = 1;
        #1;
        chk({tag, ".in_rdy"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        @(negedge clk);
        do_reset("rst0");

        // Byte lanes
        step(1, 32'h12345680, 0, 0, 0, 0, 1, 0, "b_s0");
        chk("b_s0.k", out_data, 32'hFFFFFF80);
        step(1, 32'h12345680, 3, 0, 0, 0, 1, 0, "b_s3");
        chk("b_s3.k", out_data, 32'h00000012);
        step(1, 32'h12345680, 0, 0, 1, 0, 1, 0, "b_u0");
        chk("b_u0.k", out_data, 32'h00000080);

        // Halfword lanes
        do_reset("rst1");
        step(1, 32'hBEEF1234, 2, 1, 0, 0, 1, 0, "h_s2");
        chk("h_s2.k", out_data, 32'hFFFFBEEF);
        step(1, 32'hBEEF1234, 2, 1, 1, 0, 1, 0, "h_u2");
        chk("h_u2.k", out_data, 32'h0000BEEF);
        step(1, 32'hBEEF1234, 1, 1, 0, 0, 1, 0, "h_mis");
        chk("h_mis.k", out_data, 32'h0);
        chk("h_mis.flag", {31'b0, out_misalign}, 32'd1);
        chk("h_mis.cnt", {16'b0, mis_count}, 32'd1);

        // Doubleword: second beat ignores type/addr
        step(1, 32'h11112222, 0, 3, 0, 0, 1, 0, "dw1");
        chk("dw1.k", out_data, 32'h11112222);
        chk("dw1.last", {31'b0, out_last}, 32'd0);
        step(1, 32'h33334444, 3, 0, 0, 0, 1, 0, "dw2");
        chk("dw2.k", out_data, 32'h33334444);
        chk("dw2.last", {31'b0, out_last}, 32'd1);
        step(1, 32'h12345680, 0, 0, 0, 0, 1, 0, "dw_idle");
        chk("dw_idle.k", out_data, 32'hFFFFFF80);

        // Bypass wins over type and alignment
        step(1, 32'hA5A5A5A5, 1, 2, 0, 1, 1, 0, "byp");
        chk("byp.k", out_data, 32'hA5A5A5A5);

        // Backpressure
        step(1, 32'hCAFE0001, 0, 2, 0, 0, 1, 0, "bp_a");
        for (int i = 0; i < 3; i++) begin
            step(1, 32'hCAFE0002, 0, 2, 0, 0, 0, 0, "bp_hold");
            chk("bp_hold.k", out_data, 32'hCAFE0001);
            chk("bp_hold.rdy", {31'b0, in_ready}, 32'd0);
        end
        step(1, 32'hCAFE0002, 0, 2, 0, 0, 1, 0, "bp_b");
        chk("bp_b.k", out_data, 32'hCAFE0002);
        step(1, 32'hCAFE0003, 0, 2, 0, 0, 1, 0, "bp_c");
        chk("bp_c.k", out_data, 32'hCAFE0003);
        step(0, 32'h0, 0, 0, 0, 0, 1, 0, "bp_drain");
        chk("bp_drain.vld", {31'b0, out_valid}, 32'd0);

        // Reset after the first doubleword beat drops the second beat
        step(1, 32'h11112222, 0, 3, 0, 0, 1, 0, "rdw1");
        do_reset("rst_dw");
        step(1, 32'hAAAAAA7F, 0, 0, 0, 0, 1, 0, "rdw_byte");
        chk("rdw_byte.k", out_data, 32'h0000007F);

        // Counter saturation and clear priority
        do_reset("rst2");
        for (int i = 0; i < 65534; i++)
            step(1, 32'h1, 1, 2, 0, 0, 1, 0, "sat_fill");
        chk("sat_fffe", {16'b0, mis_count}, 32'h0000FFFE);
        step(1, 32'h1, 1, 2, 0, 0, 1, 0, "sat_a");
        chk("sat_ffff", {16'b0, mis_count}, 32'h0000FFFF);
        step(1, 32'h1, 1, 2, 0, 0, 1, 0, "sat_b");
        chk("sat_hold", {16'b0, mis_count}, 32'h0000FFFF);
        step(1, 32'h1, 1, 2, 0, 0, 1, 1, "clr");
        chk("clr.cnt", {16'b0, mis_count}, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 10) < 7, $urandom, int'($urandom % 4), int'($urandom % 4),
                 $urandom % 2 == 1, ($urandom % 8) == 0, ($urandom % 4) != 0,
                 ($urandom % 32) == 0, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
